// File: rtl/pipe_hold_ctrl.sv
// ============================================================================
// Module   : pipe_hold_ctrl
// Purpose  : Hazard/flow sequencer for the 3-stage core. Merges redirects,
//            holds and interrupt entry. Optional watchdog: `STALL_WDT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hold_ctrl #(
    parameter int unsigned FLUSH_CYCLES  = 1,
    parameter int unsigned STALL_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_ex_i,
    input  logic        hold_bus_i,
    input  logic        irq_req_i,
    input  logic [31:0] irq_addr_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        irq_ack_o,
    output logic        stall_timeout_o
);

    localparam logic [3:0] c_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit         c_MULTI  = (FLUSH_CYCLES > 1);

    if (FLUSH_CYCLES == 0 || FLUSH_CYCLES > 15 ||
        STALL_TIMEOUT == 0 || STALL_TIMEOUT > 65535) begin : g_param_check
        $error("pipe_hold_ctrl: FLUSH_CYCLES or STALL_TIMEOUT out of range");
    end

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_IRQ   = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        w_jump, w_hold, w_flush, w_ack;
    logic [31:0] w_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_jump      = 1'b0;
        w_hold      = 1'b0;
        w_flush     = 1'b0;
        w_ack       = 1'b0;
        w_addr      = 32'h0;
        case (r_state)
            S_RUN: begin
                if (jump_en_i) begin
                    w_jump  = 1'b1;
                    w_addr  = jump_addr_i;
                    w_flush = 1'b1;
                    if (c_MULTI) begin
                        w_state_nxt = S_FLUSH;
                        w_cnt_nxt   = c_RELOAD;
                    end
                end else if (hold_bus_i || hold_ex_i) begin
                    w_hold = 1'b1;
                end else if (irq_req_i) begin
                    // Entry is taken next cycle so the vector load is a clean strobe.
                    w_state_nxt = S_IRQ;
                end
            end
            S_FLUSH: begin
                w_flush = 1'b1;
                if (jump_en_i) begin
                    w_jump = 1'b1;
                    w_addr = jump_addr_i;
                    if (c_MULTI) begin
                        w_cnt_nxt = c_RELOAD;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = 4'd0;
                    end
                end else if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_IRQ: begin
                w_jump  = 1'b1;
                w_flush = 1'b1;
                // A concurrent redirect wins; the level irq is retried later.
                if (jump_en_i) begin
                    w_addr = jump_addr_i;
                end else begin
                    w_addr = irq_addr_i;
                    w_ack  = 1'b1;
                end
                if (c_MULTI) begin
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = c_RELOAD;
                end else begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign jump_en_o     = w_jump;
    assign jump_addr_o   = w_addr;
    assign hold_pc_o     = w_hold;
    assign hold_if_id_o  = w_hold;
    assign flush_if_id_o = w_flush;
    assign flush_id_ex_o = w_flush;
    assign irq_ack_o     = w_ack;

`ifdef STALL_WDT_EN
    localparam logic [15:0] c_TIMEOUT = 16'(STALL_TIMEOUT);

    logic [15:0] r_wdt;
    logic        w_wdt_fire;

    assign w_wdt_fire = w_hold && ((r_wdt + 16'd1) == c_TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdt <= 16'd0;
        end else if (!w_hold || w_wdt_fire) begin
            r_wdt <= 16'd0;
        end else begin
            r_wdt <= r_wdt + 16'd1;
        end
    end

    assign stall_timeout_o = w_wdt_fire;
`else
    assign stall_timeout_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hold_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hold_ctrl
// Purpose  : Directed-vector bench; FLUSH_CYCLES=1 and =3 instances share
//            stimulus, both with STALL_TIMEOUT=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hold_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump_en_i, hold_ex_i, hold_bus_i, irq_req_i;
    logic [31:0] jump_addr_i, irq_addr_i;

    logic        j1, hp1, hi1, fi1, fe1, a1, t1;
    logic        j3, hp3, hi3, fi3, fe3, a3, t3;
    logic [31:0] ad1, ad3;

    int n_vec = 0;
    int n_err = 0;

    // Observed word: {jump, hold_pc, hold_if_id, flush_if_id, flush_id_ex, ack, timeout, addr}
    wire [38:0] w_o1 = {j1, hp1, hi1, fi1, fe1, a1, t1, ad1};
    wire [38:0] w_o3 = {j3, hp3, hi3, fi3, fe3, a3, t3, ad3};

    localparam logic [6:0] c_Z = 7'b0000000;
    localparam logic [6:0] c_J = 7'b1001100;
    localparam logic [6:0] c_F = 7'b0001100;
    localparam logic [6:0] c_H = 7'b0110000;
    localparam logic [6:0] c_A = 7'b1001110;
`ifdef STALL_WDT_EN
    localparam logic [6:0] c_T = 7'b0000001;
`else
    localparam logic [6:0] c_T = 7'b0000000;
`endif
    localparam logic [38:0] c_ZERO = {c_Z, 32'h0};

    always #5 clk = ~clk;

    pipe_hold_ctrl #(.FLUSH_CYCLES(1), .STALL_TIMEOUT(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .hold_ex_i(hold_ex_i), .hold_bus_i(hold_bus_i),
        .irq_req_i(irq_req_i), .irq_addr_i(irq_addr_i),
        .jump_en_o(j1), .jump_addr_o(ad1), .hold_pc_o(hp1), .hold_if_id_o(hi1),
        .flush_if_id_o(fi1), .flush_id_ex_o(fe1), .irq_ack_o(a1),
        .stall_timeout_o(t1)
    );

    pipe_hold_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .hold_ex_i(hold_ex_i), .hold_bus_i(hold_bus_i),
        .irq_req_i(irq_req_i), .irq_addr_i(irq_addr_i),
        .jump_en_o(j3), .jump_addr_o(ad3), .hold_pc_o(hp3), .hold_if_id_o(hi3),
        .flush_if_id_o(fi3), .flush_id_ex_o(fe3), .irq_ack_o(a3),
        .stall_timeout_o(t3)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        {jump_en_i, hold_ex_i, hold_bus_i, irq_req_i} = 4'b0000;
        jump_addr_i = 32'h0;
        irq_addr_i  = 32'h0;
        @(negedge clk);
        n_vec++; if (w_o1 !== c_ZERO) begin n_err++; $display("FAIL reset_in fc1: got %b want %b", w_o1, c_ZERO); end
        n_vec++; if (w_o3 !== c_ZERO) begin n_err++; $display("FAIL reset_in fc3: got %b want %b", w_o3, c_ZERO); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (w_o1 !== c_ZERO) begin n_err++; $display("FAIL reset_out fc1: got %b want %b", w_o1, c_ZERO); end
        n_vec++; if (w_o3 !== c_ZERO) begin n_err++; $display("FAIL reset_out fc3: got %b want %b", w_o3, c_ZERO); end
        @(posedge clk); #1;
    endtask

    // Single redirect, then a second redirect one cycle later.
    task automatic test_jump();
        logic [3:0]  vin [9] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000,
                                 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        logic [31:0] vja [9] = '{32'h100, 32'h0, 32'h0, 32'h0,
                                 32'h200, 32'h300, 32'h0, 32'h0, 32'h0};
        logic [38:0] ve1 [9] = '{{c_J, 32'h100}, c_ZERO, c_ZERO, c_ZERO,
                                 {c_J, 32'h200}, {c_J, 32'h300}, c_ZERO, c_ZERO, c_ZERO};
        logic [38:0] ve3 [9] = '{{c_J, 32'h100}, {c_F, 32'h0}, {c_F, 32'h0}, c_ZERO,
                                 {c_J, 32'h200}, {c_J, 32'h300}, {c_F, 32'h0}, {c_F, 32'h0}, c_ZERO};
        for (int c = 0; c < 9; c++) begin
            {jump_en_i, hold_ex_i, hold_bus_i, irq_req_i} = vin[c];
            jump_addr_i = vja[c];
            @(negedge clk);
            n_vec++; if (w_o1 !== ve1[c]) begin n_err++; $display("FAIL jump[%0d] fc1: got %b want %b", c, w_o1, ve1[c]); end
            n_vec++; if (w_o3 !== ve3[c]) begin n_err++; $display("FAIL jump[%0d] fc3: got %b want %b", c, w_o3, ve3[c]); end
            @(posedge clk); #1;
        end
    endtask

    // Five hold cycles with a pending irq; entry only after the hold drops.
    task automatic test_hold_irq();
        logic [3:0]  vin [10] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101,
                                  4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        logic [38:0] ve1 [10] = '{{c_H, 32'h0}, {c_H, 32'h0}, {c_H, 32'h0}, {c_H | c_T, 32'h0},
                                  {c_H, 32'h0}, c_ZERO, {c_A, 32'h40}, c_ZERO, c_ZERO, c_ZERO};
        logic [38:0] ve3 [10] = '{{c_H, 32'h0}, {c_H, 32'h0}, {c_H, 32'h0}, {c_H | c_T, 32'h0},
                                  {c_H, 32'h0}, c_ZERO, {c_A, 32'h40}, {c_F, 32'h0}, {c_F, 32'h0}, c_ZERO};
        irq_addr_i  = 32'h40;
        jump_addr_i = 32'h0;
        for (int c = 0; c < 10; c++) begin
            {jump_en_i, hold_ex_i, hold_bus_i, irq_req_i} = vin[c];
            @(negedge clk);
            n_vec++; if (w_o1 !== ve1[c]) begin n_err++; $display("FAIL hold_irq[%0d] fc1: got %b want %b", c, w_o1, ve1[c]); end
            n_vec++; if (w_o3 !== ve3[c]) begin n_err++; $display("FAIL hold_irq[%0d] fc3: got %b want %b", c, w_o3, ve3[c]); end
            @(posedge clk); #1;
        end
    endtask

    // Jump and irq in the same RUN cycle; irq is taken once the flush ends.
    task automatic test_jump_irq();
        logic [3:0]  vin [8] = '{4'b1001, 4'b0001, 4'b0001, 4'b0001,
                                 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        logic [38:0] ve1 [8] = '{{c_J, 32'h500}, c_ZERO, {c_A, 32'h80}, c_ZERO,
                                 {c_A, 32'h80}, c_ZERO, c_ZERO, c_ZERO};
        logic [38:0] ve3 [8] = '{{c_J, 32'h500}, {c_F, 32'h0}, {c_F, 32'h0}, c_ZERO,
                                 {c_A, 32'h80}, {c_F, 32'h0}, {c_F, 32'h0}, c_ZERO};
        irq_addr_i  = 32'h80;
        jump_addr_i = 32'h500;
        for (int c = 0; c < 8; c++) begin
            {jump_en_i, hold_ex_i, hold_bus_i, irq_req_i} = vin[c];
            @(negedge clk);
            n_vec++; if (w_o1 !== ve1[c]) begin n_err++; $display("FAIL jump_irq[%0d] fc1: got %b want %b", c, w_o1, ve1[c]); end
            n_vec++; if (w_o3 !== ve3[c]) begin n_err++; $display("FAIL jump_irq[%0d] fc3: got %b want %b", c, w_o3, ve3[c]); end
            @(posedge clk); #1;
        end
    endtask

    // Redirect arriving during the IRQ cycle wins; no ack, irq retried.
    task automatic test_irq_preempt();
        logic [3:0]  vin [9] = '{4'b0001, 4'b1001, 4'b0001, 4'b0001, 4'b0001,
                                 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        logic [38:0] ve1 [9] = '{c_ZERO, {c_J, 32'h600}, c_ZERO, {c_A, 32'h80}, c_ZERO,
                                 {c_A, 32'h80}, c_ZERO, c_ZERO, c_ZERO};
        logic [38:0] ve3 [9] = '{c_ZERO, {c_J, 32'h600}, {c_F, 32'h0}, {c_F, 32'h0}, c_ZERO,
                                 {c_A, 32'h80}, {c_F, 32'h0}, {c_F, 32'h0}, c_ZERO};
        irq_addr_i  = 32'h80;
        jump_addr_i = 32'h600;
        for (int c = 0; c < 9; c++) begin
            {jump_en_i, hold_ex_i, hold_bus_i, irq_req_i} = vin[c];
            @(negedge clk);
            n_vec++; if (w_o1 !== ve1[c]) begin n_err++; $display("FAIL irq_preempt[%0d] fc1: got %b want %b", c, w_o1, ve1[c]); end
            n_vec++; if (w_o3 !== ve3[c]) begin n_err++; $display("FAIL irq_preempt[%0d] fc3: got %b want %b", c, w_o3, ve3[c]); end
            @(posedge clk); #1;
        end
    endtask

    // Jump beats a concurrent hold; holds are ignored while flushing.
    task automatic test_jump_hold();
        logic [3:0]  vin [4] = '{4'b1010, 4'b0010, 4'b0010, 4'b0000};
        logic [38:0] ve1 [4] = '{{c_J, 32'h700}, {c_H, 32'h0}, {c_H, 32'h0}, c_ZERO};
        logic [38:0] ve3 [4] = '{{c_J, 32'h700}, {c_F, 32'h0}, {c_F, 32'h0}, c_ZERO};
        jump_addr_i = 32'h700;
        for (int c = 0; c < 4; c++) begin
            {jump_en_i, hold_ex_i, hold_bus_i, irq_req_i} = vin[c];
            @(negedge clk);
            n_vec++; if (w_o1 !== ve1[c]) begin n_err++; $display("FAIL jump_hold[%0d] fc1: got %b want %b", c, w_o1, ve1[c]); end
            n_vec++; if (w_o3 !== ve3[c]) begin n_err++; $display("FAIL jump_hold[%0d] fc3: got %b want %b", c, w_o3, ve3[c]); end
            @(posedge clk); #1;
        end
    endtask

    // Ten bus-wait cycles: watchdog pulses on hold cycles 4 and 8 when enabled.
    task automatic test_wdt();
        logic [38:0] exp;
        for (int c = 0; c < 11; c++) begin
            {jump_en_i, hold_ex_i, hold_bus_i, irq_req_i} = (c < 10) ? 4'b0010 : 4'b0000;
            if (c >= 10)               exp = c_ZERO;
            else if (c == 3 || c == 7) exp = {c_H | c_T, 32'h0};
            else                       exp = {c_H, 32'h0};
            @(negedge clk);
            n_vec++; if (w_o1 !== exp) begin n_err++; $display("FAIL wdt[%0d] fc1: got %b want %b", c, w_o1, exp); end
            n_vec++; if (w_o3 !== exp) begin n_err++; $display("FAIL wdt[%0d] fc3: got %b want %b", c, w_o3, exp); end
            @(posedge clk); #1;
        end
    endtask

    // Asynchronous reset in the middle of a flush with an irq pending.
    task automatic test_reset_mid();
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h900;
        @(posedge clk); #1;
        jump_en_i = 1'b0;
        @(negedge clk);
        n_vec++; if (w_o3 !== {c_F, 32'h0}) begin n_err++; $display("FAIL rst_mid_pre fc3: got %b want %b", w_o3, {c_F, 32'h0}); end
        rst_n     = 1'b0;
        irq_req_i = 1'b1;
        #1;
        n_vec++; if (w_o1 !== c_ZERO) begin n_err++; $display("FAIL rst_mid_async fc1: got %b want %b", w_o1, c_ZERO); end
        n_vec++; if (w_o3 !== c_ZERO) begin n_err++; $display("FAIL rst_mid_async fc3: got %b want %b", w_o3, c_ZERO); end
        @(posedge clk); #1;
        irq_req_i = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        n_vec++; if (w_o1 !== c_ZERO) begin n_err++; $display("FAIL rst_mid_post fc1: got %b want %b", w_o1, c_ZERO); end
        n_vec++; if (w_o3 !== c_ZERO) begin n_err++; $display("FAIL rst_mid_post fc3: got %b want %b", w_o3, c_ZERO); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_jump();
        test_hold_irq();
        test_jump_irq();
        test_irq_preempt();
        test_jump_hold();
        test_wdt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL time_limit: got expired want done");
        $fatal(1);
    end

endmodule

`default_nettype wire
